hpi_target: RTL and testbench
=============================

Name: hpi_target

Overview:
- Synthesizable HPI target (responder): the device end of the 4-register host-port bus driven by the FPGA-side HPI master interface.
- Decodes ADDR/RD_N/WR_N/CS_N strobes into accesses on an internal word RAM, an auto-incrementing address register, a bidirectional mailbox and a status register.
- Used as a loopback target on-chip and as the bus-functional peer when verifying the host path.
- Same clock domain as the master.

Parameters:
- DEPTH, 1024, number of 16-bit RAM words (power of 2).
- ADDR_W, $clog2(DEPTH), width of the word address register.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  reset; asynchronous, active-high.
- HPI_DATA  inout  16  host data bus; tristated unless a read is in progress.
- HPI_ADDR  in  2  register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- HPI_RD_N  in  1  read strobe, active-low.
- HPI_WR_N  in  1  write strobe, active-low.
- HPI_CS_N  in  1  chip select, active-low.
- hpi_int  out  1  high while a device-to-host mailbox word is pending.
- mbx_rx_data  out  16  host-to-device mailbox word.
- mbx_rx_valid  out  1  mbx_rx_data holds an unconsumed word.
- mbx_rx_ready  in  1  device consumes the word when valid&ready.
- mbx_tx_data  in  16  device-to-host mailbox word.
- mbx_tx_valid  in  1  device offers a word.
- mbx_tx_ready  out  1  high when the tx slot is empty; transfer on valid&ready.

Behaviour:
- Reset (async, immediate): HPI_DATA released (Z), hpi_int=0, mbx_rx_valid=0, mbx_tx_ready=1, address=0, all flags=0, rd_data=0. RAM contents are not reset. Reset mid-access aborts the access with no RAM, address or flag update.
- Input stage: ADDR, RD_N, WR_N, CS_N and DATA are registered once (stage S). The previous S strobes are kept for edge detection.
- rd_act = S.CS_N low & S.RD_N low & S.WR_N high.
- wr_act = S.CS_N low & S.WR_N low & S.RD_N high.
- Both strobes low: illegal. No action; HPI_DATA stays Z.
- An access fires once, on the first cycle rd_act or wr_act becomes true (rising edge). Holding a strobe low does not repeat it. Master must deassert between accesses; minimum strobe-high time is 2 clocks.
- Write actions, by register:
  - DATA: RAM[addr] <= S.DATA, then addr <= addr+1. Wraps DEPTH-1 -> 0.
  - MAILBOX: rx word <= S.DATA, mbx_rx_valid <= 1. If already valid, overwrite and set sticky ovf.
  - ADDRESS: addr <= S.DATA[ADDR_W-1:0]; upper bits ignored.
  - STATUS: no effect.
- Read actions: rd_data is loaded on the edge cycle.
  - DATA: rd_data <= RAM[addr], then addr <= addr+1 (same wrap).
  - MAILBOX: rd_data <= tx word; clears tx_full, so hpi_int=0 and mbx_tx_ready=1 next cycle.
  - ADDRESS: rd_data <= zero-extended addr.
  - STATUS: rd_data <= {13'b0, ovf, tx_full, mbx_rx_valid}; ovf clears after the read.
- Read drive: out_en is registered = rd_act. HPI_DATA = out_en ? rd_data : Z.
  - Data is valid on the bus 2 clocks after the pins go low.
  - Released 2 clocks after RD_N or CS_N rises.
  - Master must hold RD_N low at least 3 clocks and sample on the last one.
- Device-side handshakes:
  - mbx_tx_valid & mbx_tx_ready: latch the word, tx_full <= 1, hpi_int <= 1.
  - tx_valid while full: ignored (ready low).
  - mbx_rx_valid & mbx_rx_ready: mbx_rx_valid <= 0.
- Simultaneous events:
  - Host MAILBOX read in the same cycle as a device tx: the read returns the old word, and the slot stays empty this cycle (ready was already low).
  - Host MAILBOX write in the same cycle as device rx consume: the new word wins, valid stays 1, ovf is not set.

Decomposition:
- Package hpi_pkg holds:
  - the register-select localparams (HPI_REG_DATA=2'd0, HPI_REG_MBX=2'd1, HPI_REG_ADDR=2'd2, HPI_REG_STATUS=2'd3);
  - STATUS bit indices (ST_RX_FULL=0, ST_TX_FULL=1, ST_OVF=2);
  - an access-type enum {ACC_NONE, ACC_RD, ACC_WR}.
- One sub-module, hpi_target_ram: single-port DEPTH x 16 synchronous RAM with registered read, inferable as block RAM.

Test Plan:
- Reset, then read STATUS -> HPI_DATA=16'h0000 on the 3rd strobe clock; hpi_int=0, mbx_tx_ready=1.
- Write ADDRESS=16'h0010, write DATA 16'hA5A5 then 16'h5A5A, write ADDRESS=16'h0010, read DATA twice -> 16'hA5A5 then 16'h5A5A; ADDRESS read returns 16'h0012.
- Write ADDRESS=DEPTH-1, write DATA twice (16'h1111, 16'h2222) -> RAM[DEPTH-1]=16'h1111, RAM[0]=16'h2222, ADDRESS reads 16'h0001.
- Device tx 16'hBEEF -> hpi_int=1, mbx_tx_ready=0; host reads MAILBOX -> 16'hBEEF, hpi_int=0 within 1 clock; second tx offered while full is ignored.
- Host writes MAILBOX 16'h0001 then 16'h0002 with mbx_rx_ready=0 -> mbx_rx_data=16'h0002; STATUS reads 16'h0005, then 16'h0001 on the next read.
- Assert Reset mid-read (RD_N low, after data is driven) -> HPI_DATA is Z in the same cycle; address is unchanged (0 after reset) and no RAM write occurs. RD_N and WR_N both low -> HPI_DATA stays Z and no state changes.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared constants and types for the HPI target: register map, status bit layout
// and the decoded access type.
package hpi_pkg;

  localparam logic [1:0] HPI_REG_DATA   = 2'd0;
  localparam logic [1:0] HPI_REG_MBX    = 2'd1;
  localparam logic [1:0] HPI_REG_ADDR   = 2'd2;
  localparam logic [1:0] HPI_REG_STATUS = 2'd3;

  localparam int ST_RX_FULL = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_OVF     = 2;

  typedef enum logic [1:0] {ACC_NONE, ACC_RD, ACC_WR} acc_e;

endpackage

// File: rtl/hpi_target_ram.sv
// Single-port DEPTH x 16 word RAM with registered read; no reset so it maps onto block RAM.
module hpi_target_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/hpi_target.sv
// HPI target: registers the host strobes, fires one access per strobe edge and
// serves the word RAM, auto-increment address, mailboxes and status.
module hpi_target
  import hpi_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  wire  [15:0] HPI_DATA,
  input  logic [1:0]  HPI_ADDR,
  input  logic        HPI_RD_N,
  input  logic        HPI_WR_N,
  input  logic        HPI_CS_N,
  output logic        hpi_int,
  output logic [15:0] mbx_rx_data,
  output logic        mbx_rx_valid,
  input  logic        mbx_rx_ready,
  input  logic [15:0] mbx_tx_data,
  input  logic        mbx_tx_valid,
  output logic        mbx_tx_ready
);

  logic [1:0]        s_addr;
  logic [15:0]       s_data;
  logic              s_rd_n, s_wr_n, s_cs_n;
  logic              p_rd_n, p_wr_n, p_cs_n;
  logic              rd_act, wr_act, p_rd_act, p_wr_act;
  acc_e              acc;

  logic [ADDR_W-1:0] addr;
  logic [15:0]       rd_reg, ram_q, status;
  logic              ram_sel, out_en;
  logic [15:0]       tx_word;
  logic              tx_full, ovf;
  logic              ram_en, ram_we;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s_addr <= '0;
      s_data <= '0;
      s_rd_n <= 1'b1;
      s_wr_n <= 1'b1;
      s_cs_n <= 1'b1;
      p_rd_n <= 1'b1;
      p_wr_n <= 1'b1;
      p_cs_n <= 1'b1;
    end else begin
      s_addr <= HPI_ADDR;
      s_data <= HPI_DATA;
      s_rd_n <= HPI_RD_N;
      s_wr_n <= HPI_WR_N;
      s_cs_n <= HPI_CS_N;
      p_rd_n <= s_rd_n;
      p_wr_n <= s_wr_n;
      p_cs_n <= s_cs_n;
    end
  end

  // Both strobes low decodes to neither access, so it can never fire.
  assign rd_act   = ~s_cs_n & ~s_rd_n &  s_wr_n;
  assign wr_act   = ~s_cs_n & ~s_wr_n &  s_rd_n;
  assign p_rd_act = ~p_cs_n & ~p_rd_n &  p_wr_n;
  assign p_wr_act = ~p_cs_n & ~p_wr_n &  p_rd_n;

  always_comb begin
    acc = ACC_NONE;
    if (rd_act && !p_rd_act)      acc = ACC_RD;
    else if (wr_act && !p_wr_act) acc = ACC_WR;
  end

  always_comb begin
    status               = '0;
    status[ST_RX_FULL]   = mbx_rx_valid;
    status[ST_TX_FULL]   = tx_full;
    status[ST_OVF]       = ovf;
  end

  assign ram_en = (acc != ACC_NONE) && (s_addr == HPI_REG_DATA);
  assign ram_we = (acc == ACC_WR);

  // DATA reads return straight from the RAM output register, which is loaded on
  // the same edge as the other registers would load rd_reg.
  hpi_target_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk   (Clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr),
    .wdata (s_data),
    .rdata (ram_q)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr         <= '0;
      rd_reg       <= '0;
      ram_sel      <= 1'b0;
      out_en       <= 1'b0;
      tx_word      <= '0;
      tx_full      <= 1'b0;
      mbx_rx_data  <= '0;
      mbx_rx_valid <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      out_en <= rd_act;

      // Ready is ~tx_full, so a host read racing a device offer sees the old word.
      if (mbx_tx_valid && !tx_full) begin
        tx_word <= mbx_tx_data;
        tx_full <= 1'b1;
      end else if (acc == ACC_RD && s_addr == HPI_REG_MBX) begin
        tx_full <= 1'b0;
      end

      if (acc == ACC_WR && s_addr == HPI_REG_MBX) begin
        mbx_rx_data  <= s_data;
        mbx_rx_valid <= 1'b1;
        if (mbx_rx_valid && !mbx_rx_ready) ovf <= 1'b1;
      end else if (mbx_rx_valid && mbx_rx_ready) begin
        mbx_rx_valid <= 1'b0;
      end

      if (acc == ACC_RD) begin
        ram_sel <= (s_addr == HPI_REG_DATA);
        case (s_addr)
          HPI_REG_DATA:   addr   <= addr + 1'b1;
          HPI_REG_MBX:    rd_reg <= tx_word;
          HPI_REG_ADDR:   rd_reg <= 16'(addr);
          default: begin
            rd_reg <= status;
            ovf    <= 1'b0;
          end
        endcase
      end else if (acc == ACC_WR) begin
        case (s_addr)
          HPI_REG_DATA: addr <= addr + 1'b1;
          HPI_REG_ADDR: addr <= s_data[ADDR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign hpi_int      = tx_full;
  assign mbx_tx_ready = ~tx_full;
  assign HPI_DATA     = out_en ? (ram_sel ? ram_q : rd_reg) : 16'hzzzz;

endmodule

// File: tb/tb_hpi_target.sv
// Bench for hpi_target: host/device tasks update a behavioural model and queue
// expected read words; a negedge monitor pops and compares the sampled bus.
module tb_hpi_target;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [1:0] R_DATA = 2'd0, R_MBX = 2'd1, R_ADDR = 2'd2, R_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  tri1  [15:0] hpi_data;
  logic [1:0]  hpi_addr;
  logic        rd_n, wr_n, cs_n;
  logic        hpi_int;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic        tb_oe;
  logic [15:0] tb_dout;

  assign hpi_data = tb_oe ? tb_dout : 16'hzzzz;

  hpi_target #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clk(clk), .Reset(rst), .HPI_DATA(hpi_data), .HPI_ADDR(hpi_addr),
    .HPI_RD_N(rd_n), .HPI_WR_N(wr_n), .HPI_CS_N(cs_n), .hpi_int(hpi_int),
    .mbx_rx_data(rx_data), .mbx_rx_valid(rx_valid), .mbx_rx_ready(rx_ready),
    .mbx_tx_data(tx_data), .mbx_tx_valid(tx_valid), .mbx_tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model of the target as seen from its pins.
  logic [15:0] m_ram [DEPTH];
  bit          m_wr  [DEPTH];
  int          m_addr;
  logic [15:0] m_tx, m_rx;
  bit          m_txk, m_txf, m_rxv, m_ovf;

  typedef struct { logic [15:0] v; bit care; string tag; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_req = 1'b0;

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_req) begin
      mon_req = 1'b0;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard: bus sampled with nothing expected");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.care) chk(mon_e.tag, hpi_data, mon_e.v);
      end
    end
  end

  task automatic model_reset();
    m_addr = 0; m_txf = 0; m_rxv = 0; m_ovf = 0; m_txk = 0; m_tx = '0; m_rx = '0;
  endtask

  task automatic host_read(input logic [1:0] r, input string tag);
    exp_t e;
    e.care = 1; e.tag = tag;
    case (r)
      R_DATA: begin e.v = m_ram[m_addr]; e.care = m_wr[m_addr]; m_addr = (m_addr + 1) % DEPTH; end
      R_MBX:  begin e.v = m_tx; e.care = m_txk; m_txf = 0; end
      R_ADDR: e.v = 16'(m_addr);
      default: begin e.v = {13'b0, m_ovf, m_txf, m_rxv}; m_ovf = 0; end
    endcase
    exp_q.push_back(e);
    @(posedge clk); #1 hpi_addr = r; cs_n = 0; rd_n = 0;
    @(posedge clk); @(posedge clk); #1 mon_req = 1'b1;
    @(posedge clk); #1 cs_n = 1; rd_n = 1;
    @(posedge clk); @(posedge clk); #1 chk("bus_release", hpi_data, 16'hFFFF);
  endtask

  task automatic host_write(input logic [1:0] r, input logic [15:0] d);
    case (r)
      R_DATA: begin m_ram[m_addr] = d; m_wr[m_addr] = 1; m_addr = (m_addr + 1) % DEPTH; end
      R_MBX:  begin if (m_rxv) m_ovf = 1; m_rx = d; m_rxv = 1; end
      R_ADDR: m_addr = int'(d) % DEPTH;
      default: ;
    endcase
    @(posedge clk); #1 hpi_addr = r; tb_dout = d; tb_oe = 1; cs_n = 0; wr_n = 0;
    @(posedge clk); @(posedge clk); #1 cs_n = 1; wr_n = 1; tb_oe = 0;
    @(posedge clk);
  endtask

  task automatic dev_tx(input logic [15:0] d);
    if (!m_txf) begin m_tx = d; m_txk = 1; m_txf = 1; end
    @(posedge clk); #1 tx_data = d; tx_valid = 1;
    @(posedge clk); #1 tx_valid = 0;
    chk("hpi_int", {15'b0, hpi_int}, {15'b0, m_txf});
    chk("tx_ready", {15'b0, tx_ready}, {15'b0, !m_txf});
  endtask

  task automatic dev_rx_consume();
    chk("rx_valid", {15'b0, rx_valid}, {15'b0, m_rxv});
    if (m_rxv) chk("rx_data", rx_data, m_rx);
    @(posedge clk); #1 rx_ready = 1;
    @(posedge clk); #1 rx_ready = 0;
    m_rxv = 0;
    chk("rx_consumed", {15'b0, rx_valid}, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; hpi_addr = '0; rd_n = 1; wr_n = 1; cs_n = 1; rx_ready = 0;
    tx_data = '0; tx_valid = 0; tb_oe = 0; tb_dout = '0;
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("rst_bus", hpi_data, 16'hFFFF);
    chk("rst_int", {15'b0, hpi_int}, 16'h0);
    chk("rst_tx_ready", {15'b0, tx_ready}, 16'h1);
    chk("rst_rx_valid", {15'b0, rx_valid}, 16'h0);
    rst = 0;

    host_read(R_STAT, "status_after_reset");

    host_write(R_ADDR, 16'h0010);
    host_write(R_DATA, 16'hA5A5);
    host_write(R_DATA, 16'h5A5A);
    host_write(R_ADDR, 16'h0010);
    host_read(R_DATA, "ram_rd0");
    host_read(R_DATA, "ram_rd1");
    host_read(R_ADDR, "addr_incr");

    host_write(R_ADDR, 16'(DEPTH - 1));
    host_write(R_DATA, 16'h1111);
    host_write(R_DATA, 16'h2222);
    host_read(R_ADDR, "addr_wrap");
    host_write(R_ADDR, 16'(DEPTH - 1));
    host_read(R_DATA, "ram_top");
    host_read(R_DATA, "ram_zero");
    host_write(R_ADDR, 16'hFFC3);
    host_read(R_ADDR, "addr_upper_ignored");

    dev_tx(16'hBEEF);
    host_read(R_MBX, "mbx_tx_beef");
    chk("int_cleared", {15'b0, hpi_int}, 16'h0);
    dev_tx(16'h1234);
    dev_tx(16'h5678);
    host_read(R_MBX, "mbx_tx_full_ignore");

    host_write(R_MBX, 16'h0001);
    host_write(R_MBX, 16'h0002);
    chk("rx_data_last", rx_data, 16'h0002);
    host_read(R_STAT, "status_ovf");
    host_read(R_STAT, "status_ovf_cleared");
    dev_rx_consume();

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 7))
        0: host_write(R_ADDR, 16'($urandom));
        1, 2: host_write(R_DATA, 16'($urandom));
        3: host_read(R_DATA, "rnd_data");
        4: host_read(R_ADDR, "rnd_addr");
        5: host_read(R_STAT, "rnd_status");
        6: if ($urandom_range(0, 1) == 1) host_write(R_MBX, 16'($urandom)); else dev_rx_consume();
        default: if ($urandom_range(0, 1) == 1) dev_tx(16'($urandom)); else host_read(R_MBX, "rnd_mbx");
      endcase
    end

    // Reset while a DATA read is being driven
    host_write(R_ADDR, 16'h0005);
    host_write(R_DATA, 16'hC0DE);
    host_write(R_ADDR, 16'h0005);
    @(posedge clk); #1 hpi_addr = R_DATA; cs_n = 0; rd_n = 0;
    @(posedge clk); @(posedge clk); #1 chk("pre_reset_drive", hpi_data, 16'hC0DE);
    rst = 1; model_reset();
    #1 chk("reset_release_bus", hpi_data, 16'hFFFF);
    chk("reset_int", {15'b0, hpi_int}, 16'h0);
    chk("reset_tx_ready", {15'b0, tx_ready}, 16'h1);
    @(posedge clk); #1 cs_n = 1; rd_n = 1;
    @(posedge clk); #1 rst = 0;
    host_read(R_ADDR, "addr_after_reset");
    host_write(R_ADDR, 16'h0005);
    host_read(R_DATA, "ram_kept");

    // Illegal: both strobes low together
    host_write(R_ADDR, 16'h0020);
    @(posedge clk); #1 hpi_addr = R_DATA; cs_n = 0; rd_n = 0; wr_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 chk("illegal_bus_z", hpi_data, 16'hFFFF);
    end
    cs_n = 1; rd_n = 1; wr_n = 1;
    @(posedge clk); @(posedge clk);
    host_read(R_ADDR, "illegal_addr");
    host_read(R_STAT, "illegal_status");

    @(posedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
